mips_cpu_muldiv: RTL and testbench



---
 rtl/mips_cpu_muldiv_if.sv | 17 +
 rtl/mips_cpu_muldiv.sv | 141 ++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle between the execute-stage control path and the
// HI/LO multiply/divide unit.
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; signs are reapplied in a single FIX cycle.
// Optional build macro MULDIV_FAST_MULT_EN: MULT/MULTU skip RUN and use a
// combinational multiplier (one busy cycle); divide timing is unchanged.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  mips_cpu_muldiv_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] phi;     // product upper half / partial remainder
  logic [WIDTH-1:0] plo;     // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] opb;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_raw;   // original rs bits, needed for divide-by-zero HI
  logic             sa, sb;  // operand signs (always 0 for unsigned ops)
  logic             is_div;
  logic             bzero;
  logic [CW-1:0]    cnt;

  // Operand decode: signedness and magnitudes at issue time
  logic             arith, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] amag, bmag;
  always_comb begin
    arith     = ~bus.op[2];
    signed_op = arith & ~bus.op[0];
    a_neg     = signed_op & bus.a[WIDTH-1];
    b_neg     = signed_op & bus.b[WIDTH-1];
    amag      = a_neg ? -bus.a : bus.a;
    bmag      = b_neg ? -bus.b : bus.b;
  end

  // One iteration of either datapath
  logic [WIDTH:0] msum, dsh, ddiff;
  logic           dge;
  always_comb begin
    msum  = {1'b0, phi} + {1'b0, (plo[0] ? opb : {WIDTH{1'b0}})};
    dsh   = {phi, plo[WIDTH-1]};
    ddiff = dsh - {1'b0, opb};
    // remainder < divisor keeps a non-wrapping difference below 2^WIDTH,
    // so the top bit is exactly the borrow
    dge   = ~ddiff[WIDTH];
  end

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   q_c, r_c;
  always_comb begin
    prod_c = (sa ^ sb) ? -{phi, plo} : {phi, plo};
    q_c    = (sa ^ sb) ? -plo : plo;
    r_c    = sa ? -phi : phi;
  end

`ifdef MULDIV_FAST_MULT_EN
  // Magnitude product; FIX reapplies the sign just like the iterative path
  logic [2*WIDTH-1:0] fprod;
  always_comb fprod = {{WIDTH{1'b0}}, amag} * {{WIDTH{1'b0}}, bmag};
`endif

  // Control FSM and HI/LO state, all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      phi      <= '0;
      plo      <= '0;
      opb      <= '0;
      a_raw    <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      is_div   <= 1'b0;
      bzero    <= 1'b0;
      cnt      <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (arith) begin
              sa       <= a_neg;
              sb       <= b_neg;
              is_div   <= bus.op[1];
              bzero    <= (bus.b == '0);
              a_raw    <= bus.a;
              opb      <= bmag;
              phi      <= '0;
              plo      <= amag;
              cnt      <= CW'(WIDTH - 1);
              bus.busy <= 1'b1;
              state    <= RUN;
`ifdef MULDIV_FAST_MULT_EN
              if (!bus.op[1]) begin
                {phi, plo} <= fprod;
                state      <= FIX;
              end
`endif
            end else if (bus.op == 3'd4) begin
              bus.hi <= bus.a;
            end else if (bus.op == 3'd5) begin
              bus.lo <= bus.a;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            phi <= dge ? ddiff[WIDTH-1:0] : dsh[WIDTH-1:0];
            plo <= {plo[WIDTH-2:0], dge};
          end else begin
            {phi, plo} <= {msum, plo[WIDTH-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            {bus.hi, bus.lo} <= prod_c;
          end else if (bzero) begin
            bus.hi <= a_raw;
            bus.lo <= '1;
          end else begin
            bus.hi <= r_c;
            bus.lo <= q_c;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: expected HI/LO pushed to a queue at
// issue, popped and checked when done pulses.
module tb_mips_cpu_muldiv;
  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  mips_cpu_muldiv_if #(.WIDTH(W)) bus();
  mips_cpu_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference {hi,lo} built from language arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint    pa, pb;
    int        q, r;
    logic [31:0] uq, ur;
    case (op)
      3'd0: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
      end
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Issue one arithmetic op, optionally poke start mid-run, then check result
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input bit poke,
                        input bit pulse_chk);
    exp_t got;
    logic [31:0] h0, l0;
    int cyc, bcnt;
    sb.push_back('{tag, exp, ((op < 3'd2) && FAST) ? 1 : W + 1});
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    cyc = 0; bcnt = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      if (cyc == 5 && bus.busy === 1'b1) chk({tag, " hold"}, {bus.hi, bus.lo}, {h0, l0});
      if (poke && cyc == 3) begin
        bus.start = 1'b1; bus.op = 3'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    if (cyc >= 100) chk({tag, " timeout"}, 64'(bus.done), 64'h1);
    got = sb.pop_front();
    chk({got.tag, " hilo"}, {bus.hi, bus.lo}, got.exp);
    chk({got.tag, " latency"}, 64'(cyc), 64'(got.lat));
    chk({got.tag, " busy_cycles"}, 64'(bcnt), 64'(got.lat));
    chk({got.tag, " busy_low"}, 64'(bus.busy), 64'h0);
    if (pulse_chk) begin
      @(posedge clk); #1;
      chk({got.tag, " done_pulse"}, 64'(bus.done), 64'h0);
    end
  endtask

  // Move-to HI/LO: one edge, no busy, no done
  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] a,
                    input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, " hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    chk({tag, " flags"}, {62'h0, bus.busy, bus.done}, 64'h0);
    @(posedge clk); #1;
    chk({tag, " flags2"}, {62'h0, bus.busy, bus.done}, 64'h0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          seen;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.busy), 64'h0);
    chk("reset done", 64'(bus.done), 64'h0);
    chk("reset hilo", {bus.hi, bus.lo}, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    mt("mthi", 3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0);
    mt("mtlo", 3'd5, 32'h0000_0005, 32'hDEAD_BEEF, 32'h5);

    // ignored no-op codes leave HI/LO alone
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'h1111_1111;
    @(posedge clk); #1;
    bus.op = 3'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("noop hilo", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'h5});
    chk("noop busy", 64'(bus.busy), 64'h0);

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFF9, 32'h6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b1, 1'b1);
    run_op("multu_neg", 3'd1, 32'hFFFF_FFF9, 32'h6, 64'h0000_0005_FFFF_FFD6, 1'b0, 1'b0);
    // issued in the done cycle of the previous op
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1);
    run_op("divu", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b1);
    run_op("divu_by0", 3'd3, 32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF}, 1'b0, 1'b1);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, 1'b1);
    run_op("div_by0_neg", 3'd2, 32'hFFFF_FF9C, 32'h0, {32'hFFFF_FF9C, 32'hFFFF_FFFF}, 1'b0, 1'b1);
    run_op("div_mixed", 3'd2, 32'd100, 32'hFFFF_FFF9, model(3'd2, 32'd100, 32'hFFFF_FFF9), 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = (i == 5) ? 32'h1 : $urandom >> (i * 5);
      rop = 3'($urandom_range(0, 3));
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), 1'b0, 1'b1);
    end

    // reset in the middle of a divide: abort, clear, no done
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'hFFFF_FC18; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid busy", 64'(bus.busy), 64'h0);
    chk("rst_mid done", 64'(bus.done), 64'h0);
    chk("rst_mid hilo", {bus.hi, bus.lo}, 64'h0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("rst_mid quiet", 64'(seen), 64'h0);

    run_op("multu_after_rst", 3'd1, 32'd3, 32'd4, 64'd12, 1'b0, 1'b1);
    chk("sb empty", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
